step_pulse_gen: RTL and testbench

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pulse_gen.sv | 137 +++++++++++++
 tb/tb_step_pulse_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// Step pulse generator: walk/jog/run pulse trains (CLK_HZ>>5/6/7 cycle periods) or manual single steps.
// Optional STEP_GEN_LIMIT_EN adds a limit input that caps the pulses issued per start (0 = unlimited).
module step_pulse_gen #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned PULSE_W = 4
) (
    input  logic        clk100MHz,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
`ifdef STEP_GEN_LIMIT_EN
    input  logic [19:0] limit,
`endif
    output logic        step_pulse,
    output logic        busy,
    output logic [19:0] pulses_sent
);

    localparam int unsigned P_WALK = CLK_HZ >> 5;
    localparam int unsigned P_JOG  = CLK_HZ >> 6;
    localparam int unsigned P_RUN  = CLK_HZ >> 7;
    localparam int unsigned CNT_W  = $clog2(P_WALK + 1);

    // Phase counter counts down to zero, so each load is the phase length minus one.
    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] LO_WALK = CNT_W'(P_WALK - PULSE_W - 1);
    localparam logic [CNT_W-1:0] LO_JOG  = CNT_W'(P_JOG - PULSE_W - 1);
    localparam logic [CNT_W-1:0] LO_RUN  = CNT_W'(P_RUN - PULSE_W - 1);

    // IDLE: waiting for start | HI: step pulse high | LO: low gap until next rise
    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       mode_q;
    logic             step_q;
    logic             busy_q;
    logic [19:0]      pulses_sent_q;
    logic [19:0]      pulses_sent_d;
    logic [CNT_W-1:0] lo_load;
    logic             cnt_zero;
    logic             limit_hit;

`ifdef STEP_GEN_LIMIT_EN
    logic [19:0]      issued_q;

    assign limit_hit = (limit != 20'd0) && (issued_q == limit);
`else
    assign limit_hit = 1'b0;
`endif

    assign cnt_zero      = (cnt_q == '0);
    assign pulses_sent_d = (pulses_sent_q == 20'hFFFFF) ? pulses_sent_q : pulses_sent_q + 20'd1;

    always_comb begin
        lo_load = LO_RUN;
        case (mode_q)
            2'b00:   lo_load = LO_WALK;
            2'b01:   lo_load = LO_JOG;
            default: lo_load = LO_RUN;
        endcase
    end

    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mode_q        <= 2'b00;
            step_q        <= 1'b0;
            busy_q        <= 1'b0;
            pulses_sent_q <= '0;
`ifdef STEP_GEN_LIMIT_EN
            issued_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q       <= HI;
                        cnt_q         <= HI_LOAD;
                        mode_q        <= mode;
                        step_q        <= 1'b1;
                        busy_q        <= 1'b1;
                        pulses_sent_q <= pulses_sent_d;
`ifdef STEP_GEN_LIMIT_EN
                        issued_q      <= 20'd1;
`endif
                    end
                end
                HI: begin
                    if (stop || (cnt_zero && (mode_q == 2'b11 || limit_hit))) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        step_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_zero) begin
                        state_q <= LO;
                        cnt_q   <= lo_load;
                        step_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                LO: begin
                    if (stop) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        step_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_zero) begin
                        state_q       <= HI;
                        cnt_q         <= HI_LOAD;
                        step_q        <= 1'b1;
                        pulses_sent_q <= pulses_sent_d;
`ifdef STEP_GEN_LIMIT_EN
                        issued_q      <= issued_q + 20'd1;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    step_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign step_pulse  = step_q;
    assign busy        = busy_q;
    assign pulses_sent = pulses_sent_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen at CLK_HZ=1280, PULSE_W=4 (periods 40/20/10 cycles).
module tb_step_pulse_gen;

    localparam int unsigned CLK_HZ  = 1280;
    localparam int unsigned PULSE_W = 4;

    logic        clk100MHz = 1'b0;
    logic        reset, start, stop;
    logic [1:0]  mode;
    logic        step_pulse, busy;
    logic [19:0] pulses_sent;
`ifdef STEP_GEN_LIMIT_EN
    logic [19:0] limit;
`endif

    int unsigned cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    typedef struct {
        int unsigned rise;
        int unsigned width;
        logic [19:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] model_cnt;

    step_pulse_gen #(.CLK_HZ(CLK_HZ), .PULSE_W(PULSE_W)) dut (
        .clk100MHz  (clk100MHz),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
`ifdef STEP_GEN_LIMIT_EN
        .limit      (limit),
`endif
        .step_pulse (step_pulse),
        .busy       (busy),
        .pulses_sent(pulses_sent)
    );

    always #5 clk100MHz = ~clk100MHz;
    always @(posedge clk100MHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk100MHz);
    endtask

    // Pulse period from the rate rules: CLK_HZ divided by 32, 64 or 128.
    function automatic int unsigned period(input logic [1:0] m);
        return CLK_HZ / (32 << m);
    endfunction

    task automatic expect_pulse(input int unsigned rise, input int unsigned width);
        exp_t e;
        if (model_cnt != 20'hFFFFF) model_cnt = model_cnt + 20'd1;
        e.rise  = rise;
        e.width = width;
        e.cnt   = model_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every rising edge of step_pulse pops one expectation.
    logic        prev_sp = 1'b0;
    bit          in_pulse = 1'b0;
    exp_t        cur;
    int unsigned rise_at;

    always @(negedge clk100MHz) begin
        if (step_pulse === 1'b1 && prev_sp !== 1'b1) begin
            check("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("rise_cycle", 64'(cyc), 64'(cur.rise));
                check("pulses_sent_at_rise", 64'(pulses_sent), 64'(cur.cnt));
                in_pulse = 1'b1;
                rise_at  = cyc;
            end
        end else if (step_pulse !== 1'b1 && prev_sp === 1'b1 && in_pulse) begin
            check("pulse_width", 64'(cyc - rise_at), 64'(cur.width));
            in_pulse = 1'b0;
        end
        prev_sp = step_pulse;
    end

    // Continuous run of n pulses, mode disturbed while busy, then stop during the final low gap.
    task automatic run_cont(input logic [1:0] m, input int n, input logic [1:0] new_mode);
        int unsigned k, p, s;
        p = period(m);
        k = cyc;
        start = 1'b1;
        stop  = 1'b0;
        mode  = m;
        for (int i = 0; i < n; i++) expect_pulse(k + 1 + i * p, PULSE_W);
        s = k + (n - 1) * p + PULSE_W + $urandom_range(0, p - PULSE_W);
        tick(1);
        mode = new_mode;
        while (cyc < s) begin
            start = 1'($urandom_range(0, 1));
            tick(1);
        end
        start = 1'b0;
        stop  = 1'b1;
        tick(1);
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_step_pulse", 64'(step_pulse), 64'd0);
        check("count_after_stop", 64'(pulses_sent), 64'(model_cnt));
        stop = 1'b0;
        tick(2);
    endtask

    // Abort the first pulse with stop or reset during its high phase.
    task automatic abort_run(input bit use_reset);
        int unsigned k, j;
        k = cyc;
        j = $urandom_range(0, PULSE_W - 1);
        start = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        expect_pulse(k + 1, j + 1);
        tick(1);
        start = 1'b0;
        while (cyc < k + 1 + j) tick(1);
        if (use_reset) reset = 1'b1;
        else           stop  = 1'b1;
        tick(1);
        reset = 1'b0;
        stop  = 1'b0;
        if (use_reset) model_cnt = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_step_pulse", 64'(step_pulse), 64'd0);
        check("abort_count", 64'(pulses_sent), 64'(model_cnt));
        tick(2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 400000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'b00;
        model_cnt = '0;
`ifdef STEP_GEN_LIMIT_EN
        limit = '0;
`endif
        tick(3);
        check("reset_step_pulse", 64'(step_pulse), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_pulses_sent", 64'(pulses_sent), 64'd0);
        reset = 1'b0;
        tick(2);

        run_cont(2'b00, 3, 2'b00);
        run_cont(2'b10, 3, 2'b00);
        for (int i = 0; i < 6; i++)
            run_cont(2'($urandom_range(0, 2)), int'($urandom_range(2, 4)), 2'($urandom_range(0, 3)));

        // Manual mode with start held: one pulse per PULSE_W+1 cycles, idle in between.
        k = cyc;
        start = 1'b1;
        mode  = 2'b11;
        for (int i = 0; i < 4; i++) expect_pulse(k + 1 + i * (PULSE_W + 1), PULSE_W);
        while (cyc < k + 20) begin
            tick(1);
            if ((cyc - k) % (PULSE_W + 1) == 0) check("manual_gap_busy", 64'(busy), 64'd0);
        end
        start = 1'b0;
        tick(3);
        check("manual_done_busy", 64'(busy), 64'd0);

        // start and stop together in IDLE must do nothing.
        start = 1'b1;
        stop  = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        repeat (3) begin
            tick(1);
            check("start_stop_idle_busy", 64'(busy), 64'd0);
        end
        start = 1'b0;
        stop  = 1'b0;
        tick(2);

        abort_run(1'b0);
        abort_run(1'b1);
        for (int i = 0; i < 4; i++) abort_run(1'($urandom_range(0, 1)));

        // Saturation near the top of the pulse counter.
        force dut.pulses_sent_q = 20'hFFFFE;
        #1 release dut.pulses_sent_q;
        model_cnt = 20'hFFFFE;
        tick(1);
        run_cont(2'b10, 3, 2'b10);
        tick(5);
        check("saturated_hold", 64'(pulses_sent), 64'hFFFFF);

`ifdef STEP_GEN_LIMIT_EN
        limit = 20'd3;
        k = cyc;
        start = 1'b1;
        mode  = 2'b01;
        for (int i = 0; i < 3; i++) expect_pulse(k + 1 + i * period(2'b01), PULSE_W);
        tick(1);
        start = 1'b0;
        while (cyc < k + 1 + 2 * period(2'b01) + PULSE_W) tick(1);
        check("limit_busy", 64'(busy), 64'd0);
        check("limit_step_pulse", 64'(step_pulse), 64'd0);
        tick(period(2'b01) * 2);
        limit = 20'd0;
        run_cont(2'b01, 5, 2'b01);
`endif

        for (int w = 0; w < 200 && exp_q.size() > 0; w++) tick(1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
